regfile_rw_client: RTL and testbench

Initiator-side controller that drives the read and write ports of a 1r1w register file (combinational read, write on rising edge) on behalf of a val/rdy request/response interface. On reset it sweeps every entry to a known value, then serves one read or write per cycle and returns responses through a registered val/rdy output stage. It sits between pipeline or accelerator logic and a standalone regfile instance, giving the regfile a latency-insensitive front end.

---
 rtl/regfile_rw_client_pkg.sv | 23 ++
 rtl/regfile_rw_client_if.sv | 41 ++++
 rtl/regfile_rw_client_resp_reg.sv | 54 +++++
 rtl/regfile_rw_client.sv | 129 ++++++++++++
 tb/tb_regfile_rw_client.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_rw_client_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_client_pkg
//  Description : Shared request-type and controller-state encodings for the
//                regfile read/write client.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_client_pkg;

  // Request opcode carried on req_type / resp_type.
  typedef enum logic [0:0] {
    RF_REQ_READ  = 1'b0,
    RF_REQ_WRITE = 1'b1
  } rf_req_type_t;

  // Controller state: sweeping the regfile after reset, then serving requests.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_client_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_rw_client_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_rw_client_if
//  Description : val/rdy request and response channels of the regfile client.
//                master = requesting logic, slave = the client controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_rw_client_if #(
  parameter int unsigned p_data_nbits   = 32,
  parameter int unsigned p_addr_nbits   = 5,
  parameter int unsigned p_opaque_nbits = 8
) ();
  import regfile_client_pkg::*;

  // Request channel
  logic                      req_val;
  logic                      req_rdy;
  rf_req_type_t              req_type;
  logic [p_addr_nbits-1:0]   req_addr;
  logic [p_data_nbits-1:0]   req_data;
  logic [p_opaque_nbits-1:0] req_opaque;

  // Response channel
  logic                      resp_val;
  logic                      resp_rdy;
  rf_req_type_t              resp_type;
  logic [p_opaque_nbits-1:0] resp_opaque;
  logic [p_data_nbits-1:0]   resp_data;

  modport master (
    output req_val, req_type, req_addr, req_data, req_opaque, resp_rdy,
    input  req_rdy, resp_val, resp_type, resp_opaque, resp_data
  );

  modport slave (
    input  req_val, req_type, req_addr, req_data, req_opaque, resp_rdy,
    output req_rdy, resp_val, resp_type, resp_opaque, resp_data
  );

endinterface
`default_nettype wire

// File: rtl/regfile_rw_client_resp_reg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_client_resp_reg
//  Description : Single-entry val/rdy output register. A load always wins and
//                keeps the entry valid; a drain without load empties it; with
//                neither, the payload holds stable.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_client_resp_reg #(
  parameter int unsigned p_payload_nbits = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic                       drain_i,
  input  logic [p_payload_nbits-1:0] payload_i,
  output logic                       val_o,
  output logic [p_payload_nbits-1:0] payload_o
);
  import regfile_client_pkg::*;

  logic                       val_q;
  logic                       val_d;
  logic [p_payload_nbits-1:0] payload_q;
  logic [p_payload_nbits-1:0] payload_d;

  // Next-state: reload on load (covers simultaneous drain+load), clear on drain.
  always_comb begin
    val_d     = val_q;
    payload_d = payload_q;
    if (load_i) begin
      val_d     = 1'b1;
      payload_d = payload_i;
    end else if (drain_i) begin
      val_d     = 1'b0;
    end
  end

  // State register; reset drops any buffered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q     <= 1'b0;
      payload_q <= '0;
    end else begin
      val_q     <= val_d;
      payload_q <= payload_d;
    end
  end

  assign val_o     = val_q;
  assign payload_o = payload_q;

endmodule
`default_nettype wire

// File: rtl/regfile_rw_client.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_rw_client
//  Description : Latency-insensitive front end for a 1r1w regfile. Sweeps all
//                entries to p_init_value after reset, then serves one read or
//                write per cycle with a registered val/rdy response stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_rw_client #(
  parameter int unsigned             p_data_nbits   = 32,
  parameter int unsigned             p_num_entries  = 32,
  parameter int unsigned             p_opaque_nbits = 8,
  parameter logic [p_data_nbits-1:0] p_init_value   = '0,
  localparam int unsigned            c_addr_nbits   = $clog2(p_num_entries)
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_rw_client_if.slave      bus,
  output logic [c_addr_nbits-1:0] rf_read_addr,
  input  logic [p_data_nbits-1:0] rf_read_data,
  output logic                    rf_write_en,
  output logic [c_addr_nbits-1:0] rf_write_addr,
  output logic [p_data_nbits-1:0] rf_write_data,
  output logic                    init_done
);
  import regfile_client_pkg::*;

  localparam int unsigned             c_payload_nbits = 1 + p_opaque_nbits + p_data_nbits;
  localparam logic [c_addr_nbits-1:0] c_last_addr     = c_addr_nbits'(p_num_entries - 1);

  rf_client_state_t            state_q;
  logic [c_addr_nbits-1:0]     cnt_q;
  logic                        init_done_q;

  logic                        in_init;
  logic                        req_rdy;
  logic                        fire;
  logic                        is_write;
  logic                        resp_val_q;
  logic [p_data_nbits-1:0]     resp_data_d;
  logic [c_payload_nbits-1:0]  payload_d;
  logic [c_payload_nbits-1:0]  payload_q;

  // Accept a request only when serving and the output slot is free or draining.
  assign in_init  = (state_q == ST_INIT);
  assign req_rdy  = !in_init && (!resp_val_q || bus.resp_rdy);
  assign fire     = bus.req_val && req_rdy;
  assign is_write = (bus.req_type == RF_REQ_WRITE);

  // Regfile port steering: the init sweep owns the write port during INIT.
  always_comb begin
    rf_read_addr  = '0;
    rf_write_en   = 1'b0;
    rf_write_addr = '0;
    rf_write_data = '0;
    if (in_init) begin
      rf_write_en   = 1'b1;
      rf_write_addr = cnt_q;
      rf_write_data = p_init_value;
    end else begin
      rf_read_addr  = bus.req_addr;
      rf_write_en   = fire && is_write;
      rf_write_addr = bus.req_addr;
      rf_write_data = bus.req_data;
    end
  end

  // Response payload: reads capture the combinational regfile output at the
  // accepting edge; writes report zero data.
  always_comb begin
    resp_data_d = is_write ? '0 : rf_read_data;
    payload_d   = {bus.req_type, bus.req_opaque, resp_data_d};
  end

  regfile_client_resp_reg #(
    .p_payload_nbits (c_payload_nbits)
  ) u_resp_reg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (fire),
    .drain_i   (bus.resp_rdy),
    .payload_i (payload_d),
    .val_o     (resp_val_q),
    .payload_o (payload_q)
  );

  // Controller FSM: walk the init counter across every entry, then serve.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_last_addr) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.req_rdy     = req_rdy;
  assign bus.resp_val    = resp_val_q;
  assign bus.resp_type   = rf_req_type_t'(payload_q[c_payload_nbits-1]);
  assign bus.resp_opaque = payload_q[p_data_nbits +: p_opaque_nbits];
  assign bus.resp_data   = payload_q[p_data_nbits-1:0];
  assign init_done       = init_done_q;

  // Out-of-range addresses are not handled in hardware.
  a_addr_in_range: assert property (@(posedge clk) disable iff (reset)
    (!in_init && bus.req_val) |-> (int'(bus.req_addr) < int'(p_num_entries)));

  // Handshake controls must be known once reset is released.
  a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({bus.req_val, bus.resp_rdy}));

endmodule
`default_nettype wire

// File: tb/tb_regfile_rw_client.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_rw_client
//  Description : Self-checking bench for regfile_rw_client with a behavioural
//                regfile, a shadow-memory/response-queue reference model,
//                a directed vector table and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_rw_client;
  import regfile_client_pkg::*;

  localparam int unsigned c_dw   = 32;
  localparam int unsigned c_n    = 32;
  localparam int unsigned c_ow   = 8;
  localparam int unsigned c_aw   = 5;
  localparam logic [31:0] c_init = 32'h5A5A_A5A5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_rw_client_if #(
    .p_data_nbits   (c_dw),
    .p_addr_nbits   (c_aw),
    .p_opaque_nbits (c_ow)
  ) bus ();

  logic [c_aw-1:0] rf_read_addr;
  logic [c_aw-1:0] rf_write_addr;
  logic [31:0]     rf_read_data;
  logic [31:0]     rf_write_data;
  logic            rf_write_en;
  logic            init_done;

  regfile_rw_client #(
    .p_data_nbits   (c_dw),
    .p_num_entries  (c_n),
    .p_opaque_nbits (c_ow),
    .p_init_value   (c_init)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .init_done     (init_done)
  );

  // Behavioural 1r1w regfile: combinational read, write at the rising edge.
  logic [31:0] rf_mem [c_n];
  assign rf_read_data = rf_mem[rf_read_addr];
  always @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;
  end

  // Reference model: shadow memory plus in-order queue of pending responses.
  typedef struct packed {
    logic        typ;
    logic [7:0]  tag;
    logic [31:0] dat;
  } rsp_t;

  logic [31:0] mem_m [c_n];
  rsp_t        exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  logic        s_val, s_rdy, s_type;
  logic [7:0]  s_opq;
  logic [31:0] s_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reset, then verify the full init sweep cycle by cycle.
  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.req_val  = 1'b0;
    bus.resp_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_resp_val",  64'(bus.resp_val),    64'(0));
    check("rst_resp_type", 64'(bus.resp_type),   64'(0));
    check("rst_resp_opq",  64'(bus.resp_opaque), 64'(0));
    check("rst_resp_data", 64'(bus.resp_data),   64'(0));
    for (int k = 0; k < int'(c_n); k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check("init_req_rdy",   64'(bus.req_rdy),   64'(0));
      check("init_resp_val",  64'(bus.resp_val),  64'(0));
      check("init_done_low",  64'(init_done),     64'(0));
      check("init_we",        64'(rf_write_en),   64'(1));
      check("init_waddr",     64'(rf_write_addr), 64'(k));
      check("init_wdata",     64'(rf_write_data), 64'(c_init));
      check("init_raddr",     64'(rf_read_addr),  64'(0));
    end
    @(negedge clk);
    #1;
    check("init_done_high", 64'(init_done),   64'(1));
    check("ready_after",    64'(bus.req_rdy), 64'(1));
    exp_q.delete();
    for (int k = 0; k < int'(c_n); k++) mem_m[k] = c_init;
  endtask

  // One clock of traffic: drive at negedge, sample 1 time unit later, score.
  task automatic cycle(input logic v, input logic t, input int a,
                       input logic [31:0] d, input logic [7:0] o, input logic rr);
    rsp_t r;
    @(negedge clk);
    bus.req_val    = v;
    bus.req_type   = rf_req_type_t'(t);
    bus.req_addr   = c_aw'(a);
    bus.req_data   = d;
    bus.req_opaque = o;
    bus.resp_rdy   = rr;
    #1;
    s_val  = bus.resp_val;
    s_rdy  = bus.req_rdy;
    s_type = bus.resp_type;
    s_opq  = bus.resp_opaque;
    s_data = bus.resp_data;
    check("req_rdy",  64'(s_rdy), 64'(exp_q.size() == 0 || rr));
    check("resp_val", 64'(s_val), 64'(exp_q.size() != 0));
    check("rf_raddr", 64'(rf_read_addr), 64'(a));
    check("rf_we",    64'(rf_write_en),  64'(v && s_rdy && t));
    if (s_val && rr && exp_q.size() != 0) begin
      r = exp_q.pop_front();
      check("resp_type", 64'(s_type), 64'(r.typ));
      check("resp_opq",  64'(s_opq),  64'(r.tag));
      check("resp_data", 64'(s_data), 64'(r.dat));
    end
    if (v && s_rdy) begin
      if (t) begin
        check("rf_waddr", 64'(rf_write_addr), 64'(a));
        check("rf_wdata", 64'(rf_write_data), 64'(d));
        mem_m[a] = d;
        r = '{typ: 1'b1, tag: o, dat: 32'h0};
      end else begin
        r = '{typ: 1'b0, tag: o, dat: mem_m[a]};
      end
      exp_q.push_back(r);
    end
  endtask

  typedef struct {
    logic        v;
    logic        t;
    int          a;
    logic [31:0] d;
    logic [7:0]  o;
    logic [31:0] rd;
    logic        ev;
    logic        et;
    logic [7:0]  eo;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic t, input int a,
                              input logic [31:0] d, input logic [7:0] o, input logic [31:0] rd);
    vec_t x;
    x.v = v; x.t = t; x.a = a; x.d = d; x.o = o; x.rd = rd;
    x.ev = 1'b0; x.et = 1'b0; x.eo = 8'h0; x.ed = 32'h0;
    return x;
  endfunction

  vec_t tbl [23];

  initial begin
    // Directed table: each row's expected response is the previous row's request.
    tbl[0] = mk(1'b1, 1'b0, 0,  32'h0, 8'h01, c_init);
    tbl[1] = mk(1'b1, 1'b0, 5,  32'h0, 8'h02, c_init);
    tbl[2] = mk(1'b1, 1'b0, 31, 32'h0, 8'h03, c_init);
    tbl[3] = mk(1'b1, 1'b1, 3,  32'hDEAD_BEEF, 8'h11, 32'h0);
    tbl[4] = mk(1'b1, 1'b0, 3,  32'h0, 8'h12, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) begin
      tbl[5 + i]  = mk(1'b1, 1'b1, i, 32'(i * 16), 8'(8'h20 + i), 32'h0);
      tbl[13 + i] = mk(1'b1, 1'b0, i, 32'h0, 8'(8'h30 + i), 32'(i * 16));
    end
    tbl[21] = mk(1'b0, 1'b0, 0, 32'h0, 8'h00, 32'h0);
    tbl[22] = mk(1'b0, 1'b0, 0, 32'h0, 8'h00, 32'h0);
    for (int k = 1; k < 23; k++) begin
      tbl[k].ev = tbl[k-1].v;
      tbl[k].et = tbl[k-1].t;
      tbl[k].eo = tbl[k-1].o;
      tbl[k].ed = tbl[k-1].rd;
    end

    bus.req_val    = 1'b0;
    bus.req_type   = RF_REQ_READ;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_opaque = '0;
    bus.resp_rdy   = 1'b0;

    do_reset();

    for (int k = 0; k < 23; k++) begin
      cycle(tbl[k].v, tbl[k].t, tbl[k].a, tbl[k].d, tbl[k].o, 1'b1);
      check("tbl_req_rdy",  64'(s_rdy), 64'(1));
      check("tbl_resp_val", 64'(s_val), 64'(tbl[k].ev));
      if (tbl[k].ev) begin
        check("tbl_resp_type", 64'(s_type), 64'(tbl[k].et));
        check("tbl_resp_opq",  64'(s_opq),  64'(tbl[k].eo));
        check("tbl_resp_data", 64'(s_data), 64'(tbl[k].ed));
      end
    end

    // Backpressure: read addr 2, then stall for 4 cycles with a pending write.
    cycle(1'b1, 1'b0, 2, 32'h0, 8'h40, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 2, 32'h0000_0BAD, 8'h44, 1'b0);
      check("stall_req_rdy", 64'(s_rdy),  64'(0));
      check("stall_val",     64'(s_val),  64'(1));
      check("stall_data",    64'(s_data), 64'(32'h20));
      check("stall_opq",     64'(s_opq),  64'(8'h40));
    end
    cycle(1'b0, 1'b0, 2, 32'h0, 8'h00, 1'b1);
    check("release_val",  64'(s_val),  64'(1));
    check("release_data", 64'(s_data), 64'(32'h20));
    cycle(1'b0, 1'b0, 2, 32'h0, 8'h00, 1'b1);
    check("after_val", 64'(s_val), 64'(0));
    check("after_rdy", 64'(s_rdy), 64'(1));

    // Reset mid-stream with a buffered response; addr 3 must return to init.
    cycle(1'b1, 1'b1, 3, 32'h0000_1234, 8'h50, 1'b0);
    cycle(1'b0, 1'b0, 3, 32'h0, 8'h00, 1'b0);
    check("pre_rst_val", 64'(s_val), 64'(1));
    do_reset();
    cycle(1'b1, 1'b0, 3, 32'h0, 8'h51, 1'b1);
    cycle(1'b0, 1'b0, 3, 32'h0, 8'h00, 1'b1);
    check("post_rst_val",  64'(s_val),  64'(1));
    check("post_rst_data", 64'(s_data), 64'(c_init));

    // Simultaneous drain and fire: alternating read/write of addr 9.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'(i % 2), 9, 32'(32'h9000 + i), 8'(8'h60 + i), 1'b1);
      if (i > 0) begin
        check("b2b_val", 64'(s_val), 64'(1));
        check("b2b_tag", 64'(s_opq), 64'(8'h60 + i - 1));
      end
    end
    cycle(1'b0, 1'b0, 9, 32'h0, 8'h00, 1'b1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, c_n - 1)), $urandom, 8'($urandom),
            1'($urandom_range(0, 3) != 0));
    end
    cycle(1'b0, 1'b0, 0, 32'h0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 0, 32'h0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
